// File: rtl/data_mem_arbiter.sv
// Arbitrates one data-memory port between the CPU load/store path and a byte-scan engine.
// CPU has priority; a starvation counter forces a scan slot after MAX_STALL consecutive denials.
module data_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 18,
    parameter int MAX_STALL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_stall,
    input  logic              scan_start,
    input  logic [ADDR_W-1:0] scan_base,
    input  logic [LEN_W-1:0]  scan_len,
    output logic              scan_busy,
    output logic              scan_done,
    output logic [7:0]        scan_data,
    output logic              scan_valid,
    input  logic              scan_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [1:0]        state_dbg
);

    localparam int SC_W = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] scan_base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  offset;
    logic [SC_W-1:0]   stall_cnt;

    logic              scan_want;
    logic              force_slot;
    logic              scan_gnt;
    logic              cpu_gnt;
    logic              pop;
    logic              last_byte;
    logic [ADDR_W-1:0] scan_addr;

    // Consumer handshake: a byte transfers in any cycle where scan_valid && scan_ready;
    // scan_data is held stable while scan_valid && !scan_ready.
    always_comb begin
        pop        = scan_valid && scan_ready;
        scan_want  = (state == S_SCAN) && (!scan_valid || pop);
        force_slot = scan_want && (stall_cnt == SC_W'(MAX_STALL));
        scan_gnt   = scan_want && (!cpu_req || force_slot);
        cpu_gnt    = cpu_req && !scan_gnt;
        last_byte  = (offset + LEN_W'(1)) == len_q;
        scan_addr  = scan_base_q + ADDR_W'(offset);
    end

    assign cpu_stall = cpu_req && scan_gnt;
    assign cpu_rd    = cpu_gnt ? mem_rd : '0;
    assign state_dbg = state;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (cpu_gnt) begin
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_wd   = cpu_wd;
        end else if (scan_gnt) begin
            mem_addr = scan_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            scan_base_q <= '0;
            len_q       <= '0;
            offset      <= '0;
            stall_cnt   <= '0;
            scan_valid  <= 1'b0;
            scan_data   <= '0;
            scan_busy   <= 1'b0;
            scan_done   <= 1'b0;
        end else begin
            // One-entry buffer: a load in the same cycle as a pop keeps valid high.
            if (scan_gnt) begin
                scan_data  <= mem_rd[7:0];
                scan_valid <= 1'b1;
                offset     <= offset + LEN_W'(1);
            end else if (pop) begin
                scan_valid <= 1'b0;
            end

            if (scan_gnt || !scan_want)
                stall_cnt <= '0;
            else if (cpu_req && stall_cnt != SC_W'(MAX_STALL))
                stall_cnt <= stall_cnt + SC_W'(1);

            case (state)
                S_IDLE: begin
                    scan_done <= 1'b0;
                    if (scan_start) begin
                        scan_base_q <= scan_base;
                        len_q       <= scan_len;
                        offset      <= '0;
                        if (scan_len == '0) begin
                            state     <= S_DONE;
                            scan_done <= 1'b1;
                        end else begin
                            state     <= S_SCAN;
                            scan_busy <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (scan_gnt && last_byte)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!scan_valid || pop) begin
                        state     <= S_DONE;
                        scan_busy <= 1'b0;
                        scan_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    scan_busy <= 1'b0;
                    scan_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: CPU access, idle scan, starvation, backpressure,
// zero-length / ignored starts and mid-scan reset, against a small word memory model.
module tb_data_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W = 18;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wd;
  logic [DATA_W-1:0] cpu_rd;
  logic              cpu_stall;
  logic              scan_start;
  logic [ADDR_W-1:0] scan_base;
  logic [LEN_W-1:0]  scan_len;
  logic              scan_busy;
  logic              scan_done;
  logic [7:0]        scan_data;
  logic              scan_valid;
  logic              scan_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;
  logic [1:0]        state_dbg;

  logic [DATA_W-1:0] mem_arr [0:255];
  logic [7:0]        exp_q[$];
  logic [7:0]        got;
  int                errors = 0;
  int                checks = 0;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_STALL(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
    .scan_busy(scan_busy), .scan_done(scan_done), .scan_data(scan_data),
    .scan_valid(scan_valid), .scan_ready(scan_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .state_dbg(state_dbg)
  );

  // clock / memory model (combinational read, write on negedge)
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rd = mem_arr[mem_addr[7:0]];

  always @(negedge clk) begin
    if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wd;
  end

  function automatic logic [7:0] exp_byte(input int a);
    logic [7:0] b;
    b = a[7:0];
    return b ^ 8'hA5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wd = '0;
    scan_start = 0; scan_base = '0; scan_len = '0; scan_ready = 0;
    tick();
    tick();
    #1;
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    checks++; if (scan_busy !== 1'b0 || scan_done !== 1'b0 || scan_valid !== 1'b0)
      begin errors++; $display("FAIL reset_flags: got busy=%b done=%b valid=%b expected 0 0 0", scan_busy, scan_done, scan_valid); end
    checks++; if (scan_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", scan_data); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== '0 || cpu_stall !== 1'b0)
      begin errors++; $display("FAIL reset_port: got we=%b addr=%h stall=%b expected 0 0 0", mem_we, mem_addr, cpu_stall); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_only();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'd152100; cpu_wd = 32'hDEADBEEF;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'd152100 || mem_wd !== 32'hDEADBEEF)
      begin errors++; $display("FAIL t1_write_port: got we=%b addr=%0d wd=%h expected 1 152100 deadbeef", mem_we, mem_addr, mem_wd); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL t1_stall_wr: got %b expected 0", cpu_stall); end
    tick();
    cpu_we = 0;
    #1;
    checks++; if (cpu_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_readback: got %h expected deadbeef", cpu_rd); end
    checks++; if (cpu_stall !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL t1_stall_rd: got stall=%b we=%b expected 0 0", cpu_stall, mem_we); end
    tick();
    cpu_req = 0;
    #1;
    checks++; if (cpu_rd !== '0 || mem_addr !== '0) begin errors++; $display("FAIL t1_idle_port: got rd=%h addr=%h expected 0 0", cpu_rd, mem_addr); end
    tick();
  endtask

  task automatic test_idle_scan();
    int first_c, last_c, done_c, n_bytes, n_done;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_byte(i));
    scan_base = 32'd0; scan_len = 18'd8; scan_ready = 1; scan_start = 1;
    tick();
    scan_start = 0;
    first_c = -1; last_c = -1; done_c = -1; n_bytes = 0; n_done = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (c == 0) begin
        checks++; if (mem_addr !== 32'd0 || mem_we !== 1'b0 || scan_busy !== 1'b1)
          begin errors++; $display("FAIL t2_first_read: got addr=%h we=%b busy=%b expected 0 0 1", mem_addr, mem_we, scan_busy); end
      end
      if (scan_valid && scan_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL t2_extra_byte: got %h expected none", scan_data); end
        else begin
          got = exp_q.pop_front();
          if (scan_data !== got) begin errors++; $display("FAIL t2_byte: got %h expected %h", scan_data, got); end
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        n_bytes++;
      end
      if (scan_done) begin n_done++; done_c = c; end
      tick();
    end
    checks++; if (n_bytes != 8 || first_c != 1 || last_c != 8)
      begin errors++; $display("FAIL t2_timing: got n=%0d first=%0d last=%0d expected 8 1 8", n_bytes, first_c, last_c); end
    checks++; if (n_done != 1 || done_c != 9)
      begin errors++; $display("FAIL t2_done: got count=%0d cycle=%0d expected 1 9", n_done, done_c); end
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL t2_busy_end: got %b expected 0", scan_busy); end
  endtask

  task automatic test_starvation();
    int done_c, n_bytes, n_done, k;
    logic exp_stall;
    logic [ADDR_W-1:0] exp_addr;
    exp_q.delete();
    for (int i = 100; i < 103; i++) exp_q.push_back(exp_byte(i));
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'd50;
    scan_base = 32'd100; scan_len = 18'd3; scan_ready = 1; scan_start = 1;
    tick();
    scan_start = 0;
    done_c = -1; n_bytes = 0; n_done = 0; k = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      exp_stall = (c == 4 || c == 9 || c == 14);
      exp_addr = exp_stall ? 32'(100 + k) : 32'd50;
      checks++; if (cpu_stall !== exp_stall)
        begin errors++; $display("FAIL t3_stall c%0d: got %b expected %b", c, cpu_stall, exp_stall); end
      checks++; if (mem_addr !== exp_addr)
        begin errors++; $display("FAIL t3_addr c%0d: got %0d expected %0d", c, mem_addr, exp_addr); end
      if (exp_stall) k++;
      if (scan_valid && scan_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL t3_extra_byte: got %h expected none", scan_data); end
        else begin
          got = exp_q.pop_front();
          if (scan_data !== got) begin errors++; $display("FAIL t3_byte: got %h expected %h", scan_data, got); end
        end
        n_bytes++;
      end
      if (scan_done) begin n_done++; done_c = c; end
      tick();
    end
    cpu_req = 0;
    checks++; if (n_bytes != 3 || n_done != 1 || done_c != 16)
      begin errors++; $display("FAIL t3_summary: got n=%0d done=%0d at %0d expected 3 1 16", n_bytes, n_done, done_c); end
  endtask

  task automatic test_backpressure();
    int done_c, n_bytes, n_done;
    exp_q.delete();
    for (int i = 20; i < 24; i++) exp_q.push_back(exp_byte(i));
    scan_base = 32'd20; scan_len = 18'd4; scan_ready = 1; scan_start = 1;
    tick();
    scan_start = 0;
    done_c = -1; n_bytes = 0; n_done = 0;
    for (int c = 0; c < 12; c++) begin
      scan_ready = !(c >= 1 && c <= 3);
      #1;
      if (c >= 1 && c <= 3) begin
        checks++; if (scan_valid !== 1'b1 || scan_data !== exp_byte(20))
          begin errors++; $display("FAIL t4_hold c%0d: got valid=%b data=%h expected 1 %h", c, scan_valid, scan_data, exp_byte(20)); end
        checks++; if (mem_addr !== '0 || mem_we !== 1'b0)
          begin errors++; $display("FAIL t4_no_read c%0d: got addr=%0d we=%b expected 0 0", c, mem_addr, mem_we); end
      end
      if (scan_valid && scan_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL t4_extra_byte: got %h expected none", scan_data); end
        else begin
          got = exp_q.pop_front();
          if (scan_data !== got) begin errors++; $display("FAIL t4_byte: got %h expected %h", scan_data, got); end
        end
        n_bytes++;
      end
      if (scan_done) begin n_done++; done_c = c; end
      tick();
    end
    scan_ready = 1;
    checks++; if (n_bytes != 4 || n_done != 1 || done_c != 8)
      begin errors++; $display("FAIL t4_summary: got n=%0d done=%0d at %0d expected 4 1 8", n_bytes, n_done, done_c); end
  endtask

  task automatic test_len0_and_ignored_start();
    int done_c, n_bytes, n_done;
    scan_base = 32'd10; scan_len = 18'd0; scan_start = 1;
    tick();
    scan_start = 0;
    #1;
    checks++; if (scan_done !== 1'b1 || scan_busy !== 1'b0 || state_dbg !== 2'd3)
      begin errors++; $display("FAIL t5_len0_done: got done=%b busy=%b state=%0d expected 1 0 3", scan_done, scan_busy, state_dbg); end
    checks++; if (mem_addr !== '0 || scan_valid !== 1'b0)
      begin errors++; $display("FAIL t5_len0_noaccess: got addr=%0d valid=%b expected 0 0", mem_addr, scan_valid); end
    tick();
    #1;
    checks++; if (scan_done !== 1'b0 || state_dbg !== 2'd0)
      begin errors++; $display("FAIL t5_len0_pulse: got done=%b state=%0d expected 0 0", scan_done, state_dbg); end
    tick();
    exp_q.delete();
    for (int i = 40; i < 43; i++) exp_q.push_back(exp_byte(i));
    scan_base = 32'd40; scan_len = 18'd3; scan_ready = 1; scan_start = 1;
    tick();
    scan_start = 0;
    done_c = -1; n_bytes = 0; n_done = 0;
    for (int c = 0; c < 10; c++) begin
      scan_start = (c == 1);
      if (c == 1) begin scan_base = 32'd60; scan_len = 18'd7; end
      #1;
      if (scan_valid && scan_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL t5_extra_byte: got %h expected none", scan_data); end
        else begin
          got = exp_q.pop_front();
          if (scan_data !== got) begin errors++; $display("FAIL t5_byte: got %h expected %h", scan_data, got); end
        end
        n_bytes++;
      end
      if (scan_done) begin n_done++; done_c = c; end
      tick();
    end
    scan_start = 0;
    checks++; if (n_bytes != 3 || n_done != 1 || done_c != 4)
      begin errors++; $display("FAIL t5_ignored_start: got n=%0d done=%0d at %0d expected 3 1 4", n_bytes, n_done, done_c); end
  endtask

  task automatic test_reset_mid_scan();
    int n_bytes;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(exp_byte(i));
    scan_base = 32'd0; scan_len = 18'd6; scan_ready = 1; scan_start = 1;
    tick();
    scan_start = 0;
    n_bytes = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (scan_valid && scan_ready) begin
        checks++;
        got = exp_q.pop_front();
        if (scan_data !== got) begin errors++; $display("FAIL t6_byte: got %h expected %h", scan_data, got); end
        n_bytes++;
      end
      if (c == 2) rst = 1'b1;
      tick();
    end
    #1;
    checks++; if (n_bytes != 2) begin errors++; $display("FAIL t6_bytes_before: got %0d expected 2", n_bytes); end
    checks++; if (state_dbg !== 2'd0 || scan_valid !== 1'b0 || scan_busy !== 1'b0 || scan_done !== 1'b0)
      begin errors++; $display("FAIL t6_after_rst: got state=%0d valid=%b busy=%b done=%b expected 0 0 0 0", state_dbg, scan_valid, scan_busy, scan_done); end
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'd200; cpu_wd = 32'hCAFE0001;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'd200 || cpu_stall !== 1'b0)
      begin errors++; $display("FAIL t6_cpu_write_in_rst: got we=%b addr=%0d stall=%b expected 1 200 0", mem_we, mem_addr, cpu_stall); end
    tick();
    rst = 1'b0; cpu_req = 0; cpu_we = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (scan_done !== 1'b0 || scan_valid !== 1'b0)
        begin errors++; $display("FAIL t6_quiet c%0d: got done=%b valid=%b expected 0 0", c, scan_done, scan_valid); end
      tick();
    end
    cpu_req = 1;
    #1;
    checks++; if (cpu_rd !== 32'hCAFE0001) begin errors++; $display("FAIL t6_readback: got %h expected cafe0001", cpu_rd); end
    cpu_req = 0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = {24'h123456, exp_byte(i)};
    test_reset();
    test_cpu_only();
    test_idle_scan();
    test_starvation();
    test_backpressure();
    test_len0_and_ignored_start();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
